// File: rtl/serial_paralelo_sync_pkg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync_pkg
// Shared definitions for the serial-to-parallel word aligner.
//   state_t       : aligner state encoding (SEARCH / ALIGN / LOCKED)
//   DEFAULT_COMMA : default alignment symbol (8'hBC)
//   COMMA_CNT_W   : width of the consecutive-comma counter (LOCK_COUNT <= 15)
// -----------------------------------------------------------------------------
package serial_paralelo_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

    localparam int COMMA_CNT_W = 4;

endpackage

// File: rtl/serial_paralelo_sync_if.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync_if
// Bundles the data-path signals of the serial-to-parallel aligner.
//   enb     : clock enable; low holds all state and forces valid to 0
//   entrada : serial input bit, MSB of each word first
//   salidas : last word captured while locked
//   valid   : one-cycle pulse when salidas is updated
//   k_out   : high while salidas holds the comma symbol
//   active  : high while the aligner is locked
// Modports: master drives enb/entrada, slave (the aligner) drives the rest.
// -----------------------------------------------------------------------------
interface serial_paralelo_sync_if #(
    parameter int WIDTH = 8
) ();

    logic             enb;
    logic             entrada;
    logic [WIDTH-1:0] salidas;
    logic             valid;
    logic             k_out;
    logic             active;

    modport master (
        output enb,
        output entrada,
        input  salidas,
        input  valid,
        input  k_out,
        input  active
    );

    modport slave (
        input  enb,
        input  entrada,
        output salidas,
        output valid,
        output k_out,
        output active
    );

endinterface

// File: rtl/serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync
// Serial-to-parallel converter with comma-based word alignment. Bits are
// shifted in MSB first; the aligner hunts for COMMA on every bit, then
// requires LOCK_COUNT consecutive commas on word boundaries before it locks
// and starts delivering words on salidas with a one-cycle valid pulse.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low reset (has priority over enb)
//   bus   : serial_paralelo_sync_if.slave (enb, entrada, salidas, valid,
//           k_out, active)
// Parameters:
//   WIDTH      : bits per parallel word (4..32)
//   COMMA      : WIDTH-bit alignment symbol
//   LOCK_COUNT : consecutive aligned commas needed for lock (1..15)
// -----------------------------------------------------------------------------
module serial_paralelo_sync
    import serial_paralelo_sync_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEFAULT_COMMA),
    parameter int               LOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_paralelo_sync_if.slave bus
);

    localparam int                     BIT_CNT_W   = $clog2(WIDTH);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT    = BIT_CNT_W'(WIDTH - 1);
    localparam logic [COMMA_CNT_W-1:0] LOCK_TARGET = COMMA_CNT_W'(LOCK_COUNT);

    state_t                 state_q,     state_d;
    logic [WIDTH-1:0]       sr_q,        sr_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [COMMA_CNT_W-1:0] comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0]       salidas_q,   salidas_d;
    logic                   valid_q,     valid_d;
    logic                   k_out_q,     k_out_d;

    logic [WIDTH-1:0]       sr_next;
    logic                   boundary;
    logic                   next_is_comma;
    logic [BIT_CNT_W-1:0]   bit_cnt_inc;
    logic [COMMA_CNT_W-1:0] comma_cnt_inc;

    // The word is taken from the shifted value so that it appears on the
    // same edge that samples its last bit.
    assign sr_next       = {sr_q[WIDTH-2:0], bus.entrada};
    assign boundary      = (bit_cnt_q == LAST_BIT);
    assign next_is_comma = (sr_next == COMMA);
    assign bit_cnt_inc   = boundary ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    assign comma_cnt_inc = comma_cnt_q + COMMA_CNT_W'(1);

    // Next-state logic: everything holds by default and valid drops, so a
    // low enb freezes the datapath (including a pending boundary) and only
    // valid is forced low.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        salidas_d   = salidas_q;
        k_out_d     = k_out_q;
        valid_d     = 1'b0;

        if (bus.enb) begin
            sr_d = sr_next;
            case (state_q)
                SEARCH: begin
                    // Bit-by-bit hunt; a hit restarts the word counter so
                    // the next bit is bit 0 of an aligned word.
                    bit_cnt_d = '0;
                    if (next_is_comma) begin
                        comma_cnt_d = COMMA_CNT_W'(1);
                        state_d     = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt_d = bit_cnt_inc;
                    if (boundary) begin
                        if (next_is_comma) begin
                            comma_cnt_d = comma_cnt_inc;
                            if (comma_cnt_inc == LOCK_TARGET) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            comma_cnt_d = '0;
                            state_d     = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Lock is sticky; only reset leaves this state.
                    bit_cnt_d = bit_cnt_inc;
                    if (boundary) begin
                        salidas_d = sr_next;
                        k_out_d   = next_is_comma;
                        valid_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset that wins over enb.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            salidas_q   <= '0;
            valid_q     <= 1'b0;
            k_out_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            salidas_q   <= salidas_d;
            valid_q     <= valid_d;
            k_out_q     <= k_out_d;
        end
    end

    assign bus.salidas = salidas_q;
    assign bus.valid   = valid_q;
    assign bus.k_out   = k_out_q;
    assign bus.active  = (state_q == LOCKED);

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_sync
// Directed bench for serial_paralelo_sync with default parameters
// (WIDTH = 8, COMMA = 8'hBC, LOCK_COUNT = 4). Bits are driven on the falling
// edge and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_sync;

    logic clk;
    logic reset;

    int          vectors;
    int          miscompares;
    int          validSeen;
    logic [7:0]  lastSal;
    logic        lastK;

    serial_paralelo_sync_if #(.WIDTH(8)) bus ();

    serial_paralelo_sync #(
        .WIDTH      (8),
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One compared vector: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus with reset released; records any valid pulse.
    task automatic applyStimulus(input logic b, input logic en);
        @(negedge clk);
        reset       = 1'b1;
        bus.entrada = b;
        bus.enb     = en;
        @(posedge clk);
        #1;
        if (bus.valid === 1'b1) begin
            validSeen++;
            lastSal = bus.salidas;
            lastK   = bus.k_out;
        end
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(w[i], 1'b1);
        end
    endtask

    // One reset edge with enb held high, to show reset wins over enb.
    task automatic applyReset();
        @(negedge clk);
        reset       = 1'b0;
        bus.enb     = 1'b1;
        bus.entrada = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        vectors     = 0;
        miscompares = 0;
        validSeen   = 0;
        lastSal     = 8'h00;
        lastK       = 1'b0;
        reset       = 1'b0;
        bus.enb     = 1'b0;
        bus.entrada = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_salidas", 32'(bus.salidas), 32'h00);
        checkOutput("rst_valid",   32'(bus.valid),   32'h0);
        checkOutput("rst_k_out",   32'(bus.k_out),   32'h0);
        checkOutput("rst_active",  32'(bus.active),  32'h0);

        $display("[TB] aligned lock on four commas, then 0x66");
        validSeen = 0;
        repeat (3) sendWord(8'hBC);
        checkOutput("lock1_pre_active", 32'(bus.active), 32'h0);
        sendWord(8'hBC);
        checkOutput("lock1_active",     32'(bus.active), 32'h1);
        checkOutput("lock1_no_valid",   32'(validSeen),  32'd0);
        sendWord(8'h66);
        checkOutput("w66_valid_now",    32'(bus.valid),  32'h1);
        checkOutput("w66_valid_count",  32'(validSeen),  32'd1);
        checkOutput("w66_salidas",      32'(lastSal),    32'h66);
        checkOutput("w66_k_out",        32'(lastK),      32'h0);

        $display("[TB] locked: comma then 0xFF");
        validSeen = 0;
        w = 8'hBC;
        applyStimulus(w[7], 1'b1);
        checkOutput("pulse_end", 32'(bus.valid), 32'h0);
        for (int i = 6; i >= 0; i--) applyStimulus(w[i], 1'b1);
        checkOutput("wBC_valid_count", 32'(validSeen), 32'd1);
        checkOutput("wBC_salidas",     32'(lastSal),   32'hBC);
        checkOutput("wBC_k_out",       32'(lastK),     32'h1);
        validSeen = 0;
        sendWord(8'hFF);
        checkOutput("wFF_valid_count", 32'(validSeen), 32'd1);
        checkOutput("wFF_salidas",     32'(lastSal),   32'hFF);
        checkOutput("wFF_k_out",       32'(lastK),     32'h0);

        $display("[TB] enb low for five cycles mid-word");
        validSeen = 0;
        w = 8'h3C;
        for (int i = 7; i >= 4; i--) applyStimulus(w[i], 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("enb_low_no_valid", 32'(validSeen),  32'd0);
        checkOutput("enb_low_active",   32'(bus.active), 32'h1);
        for (int i = 3; i >= 0; i--) applyStimulus(w[i], 1'b1);
        checkOutput("w3C_valid_now",    32'(bus.valid),  32'h1);
        checkOutput("w3C_valid_count",  32'(validSeen),  32'd1);
        checkOutput("w3C_salidas",      32'(lastSal),    32'h3C);
        applyStimulus(1'b0, 1'b0);
        checkOutput("enb_low_valid_forced", 32'(bus.valid),   32'h0);
        checkOutput("enb_low_salidas_hold", 32'(bus.salidas), 32'h3C);

        $display("[TB] reset while locked, mid-word");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyReset();
        checkOutput("mid_rst_salidas", 32'(bus.salidas), 32'h00);
        checkOutput("mid_rst_valid",   32'(bus.valid),   32'h0);
        checkOutput("mid_rst_k_out",   32'(bus.k_out),   32'h0);
        checkOutput("mid_rst_active",  32'(bus.active),  32'h0);
        validSeen = 0;
        repeat (3) sendWord(8'hBC);
        checkOutput("relock_pre_active", 32'(bus.active), 32'h0);
        sendWord(8'hBC);
        checkOutput("relock_active",     32'(bus.active), 32'h1);
        checkOutput("relock_no_valid",   32'(validSeen),  32'd0);

        $display("[TB] lock with a three-bit offset, then 0xA5");
        applyReset();
        validSeen = 0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (3) sendWord(8'hBC);
        checkOutput("offset_pre_active", 32'(bus.active), 32'h0);
        sendWord(8'hBC);
        checkOutput("offset_active",     32'(bus.active), 32'h1);
        sendWord(8'hA5);
        checkOutput("wA5_valid_count",   32'(validSeen),  32'd1);
        checkOutput("wA5_salidas",       32'(lastSal),    32'hA5);
        checkOutput("wA5_k_out",         32'(lastK),      32'h0);

        $display("[TB] broken comma run falls back to search");
        applyReset();
        validSeen = 0;
        sendWord(8'hBC);
        sendWord(8'hBC);
        sendWord(8'h00);
        checkOutput("broken_active", 32'(bus.active), 32'h0);
        repeat (3) sendWord(8'hBC);
        checkOutput("broken_pre_active", 32'(bus.active), 32'h0);
        sendWord(8'hBC);
        checkOutput("broken_relock",     32'(bus.active), 32'h1);
        checkOutput("broken_no_valid",   32'(validSeen),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
